// File: rtl/fadd_pipe_if.sv
// Handshake bundle between FPU issue logic, the pipelined adder and writeback.
// The slave modport is the adder side, the master modport is the issuer/consumer side.
interface fadd_pipe_if #(
    parameter int EW    = 8,
    parameter int MW    = 23,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [EW+MW:0]   in_x1;
    logic [EW+MW:0]   in_x2;
    logic             in_sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [EW+MW:0]   out_y;
    logic             out_ovf;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_x1, in_x2, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_y, out_ovf, out_tag
    );

    modport slave (
        input  in_valid, in_x1, in_x2, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_y, out_ovf, out_tag
    );
endinterface

// File: rtl/fadd_pipe.sv
// Three-stage IEEE-754 add/subtract: align, add, normalise/round/pack.
// Round-to-nearest-even, full subnormal support, canonical qNaN for invalid ops.
module fadd_pipe #(
    parameter int EW    = 8,
    parameter int MW    = 23,
    parameter int TAG_W = 4
) (
    input logic        clk,
    input logic        rstn,
    fadd_pipe_if.slave bus
);
    localparam int N    = 1 + EW + MW;
    localparam int FW   = MW + 4;
    localparam int SW   = MW + 5;
    localparam int XW   = EW + 1;
    localparam int PW   = XW + MW;
    localparam int DMAX = MW + 8;
    localparam logic [EW-1:0] EMAX = {EW{1'b1}};
    localparam logic [N-1:0]  QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    typedef struct packed {
        logic             sign;
        logic             zs;
        logic             esub;
        logic [EW-1:0]    exp;
        logic [FW-1:0]    ma;
        logic [FW-1:0]    mb;
        logic             spc;
        logic [N-1:0]     spv;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic             sign;
        logic             zs;
        logic [EW-1:0]    exp;
        logic [SW-1:0]    sum;
        logic             spc;
        logic [N-1:0]     spv;
        logic [TAG_W-1:0] tag;
    } s2_t;

    typedef struct packed {
        logic [N-1:0]     y;
        logic             ovf;
        logic [TAG_W-1:0] tag;
    } s3_t;

    logic v1_q, v2_q, v3_q;
    logic en1, en2, en3;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    s3_t  s3_d, s3_q;

    assign en3           = !v3_q || bus.out_ready;
    assign en2           = !v2_q || en3;
    assign en1           = !v1_q || en2;
    assign bus.in_ready  = en1;
    assign bus.out_valid = v3_q;
    assign bus.out_y     = s3_q.y;
    assign bus.out_ovf   = s3_q.ovf;
    assign bus.out_tag   = s3_q.tag;

    function automatic int lzc(input logic [FW-1:0] v);
        int n;
        n = FW;
        for (int i = 0; i < FW; i++)
            if (v[i]) n = FW - 1 - i;
        return n;
    endfunction

    logic               sa, sb, a_big;
    logic               nan_a, nan_b, inf_a, inf_b;
    logic [EW-1:0]      ea, eb, el, es, del, des, diff;
    logic [MW-1:0]      fa, fb, fl, fs;
    logic [FW+DMAX-1:0] wide;
    int                 dsh;

    // Stage 1: unpack, order by magnitude, align the smaller operand with sticky.
    always_comb begin
        s1_d  = '0;
        sa    = bus.in_x1[N-1];
        sb    = bus.in_x2[N-1] ^ bus.in_sub;
        ea    = bus.in_x1[N-2:MW];
        eb    = bus.in_x2[N-2:MW];
        fa    = bus.in_x1[MW-1:0];
        fb    = bus.in_x2[MW-1:0];
        a_big = bus.in_x1[N-2:0] >= bus.in_x2[N-2:0];
        el    = a_big ? ea : eb;
        es    = a_big ? eb : ea;
        fl    = a_big ? fa : fb;
        fs    = a_big ? fb : fa;
        del   = (el == '0) ? EW'(1) : el;
        des   = (es == '0) ? EW'(1) : es;
        diff  = del - des;
        dsh   = (int'(diff) > DMAX) ? DMAX : int'(diff);
        wide  = {es != '0, fs, 3'b000, {DMAX{1'b0}}} >> dsh;
        nan_a = (ea == EMAX) && (fa != '0);
        nan_b = (eb == EMAX) && (fb != '0);
        inf_a = (ea == EMAX) && (fa == '0);
        inf_b = (eb == EMAX) && (fb == '0);
        s1_d.sign = a_big ? sa : sb;
        s1_d.zs   = sa & sb;
        s1_d.esub = sa ^ sb;
        s1_d.exp  = del;
        s1_d.ma   = {el != '0, fl, 3'b000};
        s1_d.mb   = wide[FW+DMAX-1:DMAX] | FW'(|wide[DMAX-1:0]);
        s1_d.spc  = (ea == EMAX) || (eb == EMAX);
        if (nan_a || nan_b || (inf_a && inf_b && (sa != sb)))
            s1_d.spv = QNAN;
        else if (inf_a)
            s1_d.spv = {sa, EMAX, {MW{1'b0}}};
        else
            s1_d.spv = {sb, EMAX, {MW{1'b0}}};
        s1_d.tag = bus.in_tag;
    end

    // Stage 2: magnitude add or subtract; the larger operand is always ma.
    always_comb begin
        s2_d      = '0;
        s2_d.sign = s1_q.sign;
        s2_d.zs   = s1_q.zs;
        s2_d.exp  = s1_q.exp;
        s2_d.sum  = s1_q.esub ? ({1'b0, s1_q.ma} - {1'b0, s1_q.mb})
                              : ({1'b0, s1_q.ma} + {1'b0, s1_q.mb});
        s2_d.spc  = s1_q.spc;
        s2_d.spv  = s1_q.spv;
        s2_d.tag  = s1_q.tag;
    end

    logic [FW-1:0] norm;
    logic [XW-1:0] er, ef;
    logic [PW-1:0] pk;
    logic          inc;
    int            lz, lim, sh;

    // Stage 3: normalise without going below the minimum exponent, round, pack.
    always_comb begin
        s3_d = '0;
        lz   = lzc(s2_q.sum[FW-1:0]);
        lim  = (s2_q.exp == '0) ? 0 : int'(s2_q.exp) - 1;
        sh   = 0;
        if (s2_q.sum[SW-1]) begin
            norm = {s2_q.sum[SW-1:2], s2_q.sum[1] | s2_q.sum[0]};
            er   = {1'b0, s2_q.exp} + XW'(1);
        end else begin
            sh   = (lz < lim) ? lz : lim;
            norm = s2_q.sum[FW-1:0] << sh;
            er   = {1'b0, s2_q.exp} - XW'(sh);
        end
        ef  = norm[FW-1] ? er : '0;
        inc = norm[2] & (norm[3] | norm[1] | norm[0]);
        pk  = {ef, norm[FW-2:3]} + PW'(inc);
        s3_d.tag = s2_q.tag;
        if (s2_q.spc) begin
            s3_d.y = s2_q.spv;
        end else if (s2_q.sum == '0) begin
            s3_d.y = {s2_q.zs, {(N-1){1'b0}}};
        end else if (pk[PW-1:MW] >= {1'b0, EMAX}) begin
            s3_d.y   = {s2_q.sign, EMAX, {MW{1'b0}}};
            s3_d.ovf = 1'b1;
        end else begin
            s3_d.y = {s2_q.sign, pk[EW+MW-1:0]};
        end
    end

    // Stage 1 register: take a new op whenever the stage has room.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q <= 1'b0;
            s1_q <= '0;
        end else if (en1) begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) s1_q <= s1_d;
        end
    end

    // Stage 2 register: advance from stage 1 when there is room.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2_q <= 1'b0;
            s2_q <= '0;
        end else if (en2) begin
            v2_q <= v1_q;
            if (v1_q) s2_q <= s2_d;
        end
    end

    // Stage 3 register drives the outputs; frozen while the consumer stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v3_q <= 1'b0;
            s3_q <= '0;
        end else if (en3) begin
            v3_q <= v2_q;
            if (v2_q) s3_q <= s3_d;
        end
    end
endmodule
